// File: rtl/axi_stream_upsizer_pkg.sv
// axi_stream_upsizer_pkg: shared AXI4-Stream width constants
package axi_stream_upsizer_pkg;
  localparam int AXIS_NARROW_W      = 256;
  localparam int AXIS_WIDE_W        = 512;
  localparam int AXIS_NARROW_KEEP_W = AXIS_NARROW_W / 8;
  localparam int AXIS_WIDE_KEEP_W   = AXIS_WIDE_W / 8;
endpackage

// File: rtl/axi_stream_upsizer.sv
// axi_stream_upsizer: packs pairs of 256-bit AXI4-Stream beats into 512-bit beats; odd tails are zero-padded
module axi_stream_upsizer
  import axi_stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH  = AXIS_NARROW_W,
  parameter int OUT_WIDTH = AXIS_WIDE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_WIDTH-1:0]    in_tdata,
  input  logic [IN_WIDTH/8-1:0]  in_tkeep,
  input  logic                   in_tvalid,
  input  logic                   in_tlast,
  output logic                   in_tready,
  output logic [OUT_WIDTH-1:0]   out_tdata,
  output logic [OUT_WIDTH/8-1:0] out_tkeep,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  input  logic                   out_tready
);
  typedef enum logic {EMPTY, HALF} state_t;
  if (IN_WIDTH != AXIS_NARROW_W || OUT_WIDTH != AXIS_WIDE_W) begin : g_bad_width
    $error("axi_stream_upsizer supports only 256 -> 512 bit conversion");
  end
  state_t                state;
  logic [IN_WIDTH-1:0]   half_data;
  logic [IN_WIDTH/8-1:0] half_keep;
  logic                  accept;
  assign in_tready = !out_tvalid || out_tready;
  assign accept    = in_tvalid && in_tready;
  // A completing beat is one arriving in HALF, or a tlast beat arriving in EMPTY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      half_data  <= '0;
      half_keep  <= '0;
    end else if (accept && state == EMPTY && !in_tlast) begin
      state     <= HALF;
      half_data <= in_tdata;
      half_keep <= in_tkeep;
      if (out_tready) out_tvalid <= 1'b0;
    end else if (accept) begin
      state      <= EMPTY;
      out_tvalid <= 1'b1;
      out_tdata  <= state == HALF ? {in_tdata, half_data} : {{IN_WIDTH{1'b0}}, in_tdata};
      out_tkeep  <= state == HALF ? {in_tkeep, half_keep} : {{(IN_WIDTH/8){1'b0}}, in_tkeep};
      out_tlast  <= in_tlast;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_stream_upsizer.sv
// tb_axi_stream_upsizer: directed and randomised self-checking bench for axi_stream_upsizer
module tb_axi_stream_upsizer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] in_tdata = '0;
  logic [31:0]  in_tkeep = '0;
  logic         in_tvalid = 1'b0;
  logic         in_tlast = 1'b0;
  logic         in_tready;
  logic [511:0] out_tdata;
  logic [63:0]  out_tkeep;
  logic         out_tvalid;
  logic         out_tlast;
  logic         out_tready = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [576:0] got_q[$];
  logic [576:0] exp_q[$];
  int           t_q[$];
  logic         src_done;
  axi_stream_upsizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && out_tvalid && out_tready) begin
      got_q.push_back({out_tlast, out_tkeep, out_tdata});
      t_q.push_back(cyc);
    end
  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    logic acc;
    int   n;
    n = 0;
    in_tdata = d;
    in_tkeep = k;
    in_tlast = l;
    in_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_tready;
      tick();
      if (acc) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
    in_tvalid = 1'b0;
  endtask
  function automatic logic [576:0] word(input logic l, input logic [63:0] k, input logic [511:0] d);
    return {l, k, d};
  endfunction
  localparam logic [31:0] KF = 32'hFFFF_FFFF;
  logic [255:0] a, b, c, d;
  initial begin
    a = {8{32'hAAAA_0001}};
    b = {8{32'hBBBB_0002}};
    c = {8{32'hCCCC_0003}};
    d = {8{32'hDDDD_0004}};
    repeat (2) tick();
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tkeep", out_tkeep, 0);
    chk("rst_tlast", out_tlast, 0);
    rst_n = 1'b1;
    chk("rst_in_tready", in_tready, 1);
    // two-beat packet
    out_tready = 1'b1;
    send_beat(a, KF, 1'b0);
    chk("t1_no_early_valid", out_tvalid, 0);
    send_beat(b, KF, 1'b1);
    chk("t1_word", word(out_tlast, out_tkeep, out_tdata) & {577{out_tvalid}}, word(1'b1, {KF, KF}, {b, a}));
    tick();
    chk("t1_valid_clears", out_tvalid, 0);
    // three-beat packet with zero-padded tail
    send_beat(a, KF, 1'b0);
    send_beat(b, KF, 1'b0);
    chk("t2_word0", word(out_tlast, out_tkeep, out_tdata) & {577{out_tvalid}}, word(1'b0, {KF, KF}, {b, a}));
    send_beat(c, 32'h0000_00FF, 1'b1);
    chk("t2_word1", word(out_tlast, out_tkeep, out_tdata) & {577{out_tvalid}}, word(1'b1, 64'hFF, {256'b0, c}));
    tick();
    // 100 beats streamed with output always ready
    got_q.delete();
    t_q.delete();
    begin
      int stalls;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
        in_tdata = {8{i}};
        in_tkeep = KF;
        in_tlast = (i == 99);
        in_tvalid = 1'b1;
        @(negedge clk);
        if (!in_tready) stalls++;
        tick();
      end
      in_tvalid = 1'b0;
      repeat (3) tick();
      chk("t3_stalls", stalls, 0);
      chk("t3_words", got_q.size(), 50);
      if (got_q.size() == 50) begin
        chk("t3_first", got_q[0], word(1'b0, {KF, KF}, {{8{32'd1}}, {8{32'd0}}}));
        chk("t3_last", got_q[49], word(1'b1, {KF, KF}, {{8{32'd99}}, {8{32'd98}}}));
        chk("t3_span", t_q[49] - t_q[0], 98);
      end
    end
    // backpressure: output held for 10 cycles with a full output register
    got_q.delete();
    out_tready = 1'b0;
    send_beat(a, KF, 1'b0);
    send_beat(b, 32'h0F0F_0F0F, 1'b0);
    begin
      logic [511:0] snap;
      int           bad;
      snap = out_tdata;
      bad = 0;
      in_tdata = c;
      in_tkeep = KF;
      in_tlast = 1'b0;
      in_tvalid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (out_tdata !== snap || !out_tvalid || in_tready) bad++;
        tick();
      end
      chk("t4_stable", bad, 0);
      chk("t4_in_tready_low", in_tready, 0);
      chk("t4_held_data", out_tdata, {b, a});
    end
    out_tready = 1'b1;
    send_beat(c, KF, 1'b0);
    send_beat(d, 32'h1, 1'b1);
    repeat (3) tick();
    chk("t4_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t4_w0", got_q[0], word(1'b0, {32'h0F0F_0F0F, KF}, {b, a}));
      chk("t4_w1", got_q[1], word(1'b1, {32'h1, KF}, {d, c}));
    end
    // reset with a pending low half
    send_beat(a, KF, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_tvalid", out_tvalid, 0);
    rst_n = 1'b1;
    chk("t5_in_tready", in_tready, 1);
    got_q.delete();
    send_beat(c, KF, 1'b0);
    send_beat(d, KF, 1'b1);
    repeat (3) tick();
    chk("t5_words", got_q.size(), 1);
    if (got_q.size() == 1) chk("t5_w0", got_q[0], word(1'b1, {KF, KF}, {d, c}));
    // random packets with random valid/ready
    got_q.delete();
    exp_q.delete();
    src_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          int           len;
          logic [255:0] lo_d, bd;
          logic [31:0]  lo_k, bk;
          len = $urandom_range(1, 9);
          for (int j = 0; j < len; j++) begin
            for (int w = 0; w < 8; w++) bd[w*32 +: 32] = $urandom;
            case ($urandom % 4)
              0: bk = '0;
              1: bk = KF;
              default: bk = $urandom;
            endcase
            if (j % 2 == 0) begin
              lo_d = bd;
              lo_k = bk;
              if (j == len - 1) exp_q.push_back(word(1'b1, {32'b0, bk}, {256'b0, bd}));
            end else begin
              exp_q.push_back(word(j == len - 1, {bk, lo_k}, {bd, lo_d}));
            end
            if ($urandom % 2) tick();
            send_beat(bd, bk, j == len - 1);
          end
        end
        src_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!(src_done && got_q.size() >= exp_q.size()) && n < 60000) begin
          tick();
          out_tready = $urandom % 2;
          n++;
        end
        out_tready = 1'b1;
      end
    join
    repeat (2) tick();
    chk("t6_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk($sformatf("t6_w%0d", i), got_q[i], exp_q[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_stream_upsizer.md
AXI_STREAM_UPSIZER -- requirements
Module: axi_stream_upsizer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 256, meaning input tdata width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 512, meaning output tdata width in bits.
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port in, AXI4S slave, IN_WIDTH data / IN_WIDTH/8 keep, 1 tvalid/tready/tlast, the narrow input stream.
REQ-006 The block SHALL have port out, AXI4S master, OUT_WIDTH data / OUT_WIDTH/8 keep, 1 tvalid/tready/tlast, the packed wide output stream.
REQ-007 Elaboration SHALL fail unless IN_WIDTH == 256 and OUT_WIDTH == 512.

Function
REQ-008 The block SHALL hold two states: EMPTY (no half-word pending) and HALF (low half captured, awaiting upper beat).
REQ-009 An input beat SHALL be accepted when in.tvalid && in.tready.
REQ-010 in.tready SHALL equal !out_valid_q || out.tready, where out_valid_q is the registered output valid.
REQ-011 In EMPTY, an accepted beat with tlast=0 SHALL be stored as low half (data[255:0], keep[31:0]); transition to HALF.
REQ-012 In EMPTY, an accepted beat with tlast=1 SHALL load the output register: low half = beat, upper data = 0, upper keep = 0, tlast=1; stay EMPTY.
REQ-013 In HALF, an accepted beat SHALL load the output register: low half = stored half, upper half = beat, tlast = beat tlast; transition to EMPTY.
REQ-014 Output tdata/tkeep/tlast/tvalid SHALL be driven from registers only; latency = 1 cycle from acceptance of the completing beat to out.tvalid=1.
REQ-015 Once asserted, out.tvalid and output payload SHALL stay stable until out.tready=1.
REQ-016 A cycle with out.tready=1 and a completing beat accepted SHALL reload the output register (back-to-back), no bubble.
REQ-017 Without a new completing beat, out.tready=1 with out.tvalid=1 SHALL clear out.tvalid next cycle.
REQ-018 Sustained throughput SHALL be one output word per two input beats; input SHALL never stall while the output is drained each cycle.
REQ-019 Low-half capture SHALL occur in EMPTY even while the output register is valid, provided in.tready=1 per REQ-010.
REQ-020 Input keep SHALL be passed unmodified; beats with tkeep=0 SHALL be packed as ordinary beats (no compaction).
REQ-021 A packet of odd beat count SHALL end with a zero-padded upper half; no half-word SHALL cross a tlast boundary.

Reset
REQ-022 On rst_n=0 at a clk edge: state=EMPTY, out.tvalid=0; out.tdata/tkeep/tlast SHALL reset to 0.
REQ-023 Reset mid-packet SHALL discard the pending half and any unsent output word; the first beat after reset SHALL be a low half.
REQ-024 in.tready SHALL be 1 in the first cycle after reset release.

Structure
REQ-025 AXI width constants (256, 512, keep widths 32/64) SHALL live in the shared libstf AXI package; the state enum (EMPTY, HALF) SHALL be local.
REQ-026 The block SHALL be a single module; no sub-module.

Verification
REQ-027 Beats A (keep all 1s, tlast=0), B (tlast=1), out.tready=1 -> one word {B,A}, keep 64'hFFFF_FFFF_FFFF_FFFF, tlast=1, out.tvalid 1 cycle after B accepted.
REQ-028 Three beats A,B,C (C tlast=1, keep 32'h0000_00FF) -> {B,A} tlast=0, then {0,C} with keep 64'h0000_0000_0000_00FF, tlast=1.
REQ-029 Continuous input of 100 beats with out.tready=1 -> 50 words, in.tready never 0, no gaps after first output.
REQ-030 out.tready held 0 for 10 cycles with words pending -> out payload stable, in.tready=0 after output register fills, no beat lost or duplicated when released.
REQ-031 rst_n=0 after accepting low half A, then beats C,D (D tlast=1) -> only {D,C} emitted; A never appears.
REQ-032 Random tvalid/tready (50%) over 1000 packets of random length 1-9 -> scoreboard match of data, keep and tlast per packet.
